mem_loader: RTL and testbench



---
 rtl/mem_loader.sv | 240 ++++++++++++++++++++++++
 tb/tb_mem_loader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// -----------------------------------------------------------------------------
// mem_loader -- boot-time initiator for the memory block's read/write data port.
//
// Accepts a byte stream from the host link (valid/ready), parses a 4-byte
// little-endian length header (length in 32-bit words), assembles little-endian
// words from the following bytes and issues one single-cycle write per word on
// the memory data port. o_done / o_error report the outcome and are held until
// the next i_start or reset, so the processor can be released from reset.
//
// Optional feature macro: MEM_LOADER_CHECKSUM_EN
//   When defined, a 32-bit running sum (mod 2^32) of all data words is kept
//   and a 4-byte little-endian trailer holding the expected sum follows the
//   data. A match ends in DONE, a mismatch in ERROR (written words stay).
//   When undefined there is no trailer and the final word leads to DONE.
//
// Parameters:
//   BASE_ADDR  byte address of word 0 (multiple of 4)
//   MAX_WORDS  largest accepted image length in words
//
// Ports:
//   i_clk      clock
//   i_rst      synchronous, active-high reset
//   i_start    single-cycle pulse that begins a load (IDLE/DONE/ERROR only)
//   i_s_valid  stream byte valid
//   i_s_data   stream byte
//   o_s_ready  loader accepts a byte this cycle
//   o_d_valid  data-port write request (one cycle per word)
//   o_d_we     write enable, mirrors o_d_valid
//   o_d_addr   byte address of the word being written
//   o_d_data   word being written
//   o_busy     load in progress
//   o_done     load completed successfully
//   o_error    load aborted
// -----------------------------------------------------------------------------

package hex_pkg;
  localparam int unsigned MEM_DEPTH = 1024;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
endpackage

module mem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = hex_pkg::MEM_DEPTH
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic           i_s_valid,
  input  logic [7:0]     i_s_data,
  output logic           o_s_ready,
  output logic           o_d_valid,
  output logic           o_d_we,
  output hex_pkg::addr_t o_d_addr,
  output hex_pkg::data_t o_d_data,
  output logic           o_busy,
  output logic           o_done,
  output logic           o_error
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_DATA   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  state_t      state;
  logic [1:0]  byte_cnt;   // position of the next byte within the current 4-byte group
  logic [31:0] word_cnt;   // index k of the next data word
  logic [31:0] length;     // image length L in words
  logic [23:0] part;       // first three bytes of the group, byte 0 in the low bits
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [31:0] sum;        // running sum of data words, mod 2^32
`endif

  logic           byte_fire;
  logic           last_byte;
  hex_pkg::data_t word_now;

  // Joins the three buffered bytes with the incoming fourth byte (little-endian).
  function automatic hex_pkg::data_t assemble_word(input logic [23:0] lower,
                                                   input logic [7:0]  top);
    return {top, lower};
  endfunction

  // Byte address of word k; the sum wraps and is truncated to the address width.
  function automatic hex_pkg::addr_t word_addr(input logic [29:0] k);
    return hex_pkg::addr_t'(BASE_ADDR + {k, 2'b00});
  endfunction

  // Handshake decode and the word formed if the current byte completes a group.
  always_comb begin
    byte_fire = i_s_valid && o_s_ready;
    last_byte = byte_fire && (byte_cnt == 2'd3);
    word_now  = assemble_word(part, i_s_data);
  end

  // Loader FSM with all outputs registered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      byte_cnt  <= 2'd0;
      word_cnt  <= 32'd0;
      length    <= 32'd0;
      part      <= 24'd0;
`ifdef MEM_LOADER_CHECKSUM_EN
      sum       <= 32'd0;
`endif
      o_s_ready <= 1'b0;
      o_d_valid <= 1'b0;
      o_d_we    <= 1'b0;
      o_d_addr  <= '0;
      o_d_data  <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_error   <= 1'b0;
    end else begin
      // The write strobe is a one-cycle pulse unless a word completes this cycle.
      o_d_valid <= 1'b0;
      o_d_we    <= 1'b0;

      // Bytes are shifted in from the top so byte 0 ends up in part[7:0].
      if (byte_fire) begin
        byte_cnt <= byte_cnt + 2'd1;
        part     <= {i_s_data, part[23:8]};
      end else begin
        byte_cnt <= byte_cnt;
        part     <= part;
      end

      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (i_start) begin
            state     <= ST_HEADER;
            byte_cnt  <= 2'd0;
            word_cnt  <= 32'd0;
            length    <= 32'd0;
            part      <= 24'd0;
`ifdef MEM_LOADER_CHECKSUM_EN
            sum       <= 32'd0;
`endif
            o_s_ready <= 1'b1;
            o_busy    <= 1'b1;
            o_done    <= 1'b0;
            o_error   <= 1'b0;
          end else begin
            state <= state;
          end
        end

        ST_HEADER: begin
          if (last_byte) begin
            length <= word_now;
            if (word_now > 32'(MAX_WORDS)) begin
              state     <= ST_ERROR;
              o_s_ready <= 1'b0;
              o_busy    <= 1'b0;
              o_error   <= 1'b1;
            end else if (word_now == 32'd0) begin
`ifdef MEM_LOADER_CHECKSUM_EN
              // Empty image still carries a trailer, which must be zero.
              state <= ST_CHECK;
`else
              state     <= ST_DONE;
              o_s_ready <= 1'b0;
              o_busy    <= 1'b0;
              o_done    <= 1'b1;
`endif
            end else begin
              state <= ST_DATA;
            end
          end else begin
            state <= ST_HEADER;
          end
        end

        ST_DATA: begin
          if (last_byte) begin
            o_d_valid <= 1'b1;
            o_d_we    <= 1'b1;
            o_d_addr  <= word_addr(word_cnt[29:0]);
            o_d_data  <= word_now;
            word_cnt  <= word_cnt + 32'd1;
`ifdef MEM_LOADER_CHECKSUM_EN
            sum       <= sum + word_now;
`endif
            // Leaving DATA shares the edge with the final write strobe.
            if (word_cnt == (length - 32'd1)) begin
`ifdef MEM_LOADER_CHECKSUM_EN
              state <= ST_CHECK;
`else
              state     <= ST_DONE;
              o_s_ready <= 1'b0;
              o_busy    <= 1'b0;
              o_done    <= 1'b1;
`endif
            end else begin
              state <= ST_DATA;
            end
          end else begin
            state <= ST_DATA;
          end
        end

`ifdef MEM_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (last_byte) begin
            o_s_ready <= 1'b0;
            o_busy    <= 1'b0;
            if (word_now == sum) begin
              state  <= ST_DONE;
              o_done <= 1'b1;
            end else begin
              state   <= ST_ERROR;
              o_error <= 1'b1;
            end
          end else begin
            state <= ST_CHECK;
          end
        end
`endif

        default: begin
          // Unreachable encodings recover to a quiet IDLE.
          state     <= ST_IDLE;
          o_s_ready <= 1'b0;
          o_busy    <= 1'b0;
          o_done    <= 1'b0;
          o_error   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_mem_loader -- self-checking bench for mem_loader.
// Stimulus issues random and directed loads; each expected write is pushed to a
// queue as the word's last byte is handed over, and a negedge monitor pops and
// compares every strobe the DUT produces. Works with or without
// MEM_LOADER_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module tb_mem_loader;

  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int unsigned MAXW = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           s_valid = 1'b0;
  logic [7:0]     s_data = 8'h00;
  logic           s_ready;
  logic           d_valid;
  logic           d_we;
  hex_pkg::addr_t d_addr;
  hex_pkg::data_t d_data;
  logic           busy;
  logic           done;
  logic           error;

  mem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_s_valid(s_valid), .i_s_data(s_data), .o_s_ready(s_ready),
    .o_d_valid(d_valid), .o_d_we(d_we), .o_d_addr(d_addr), .o_d_data(d_data),
    .o_busy(busy), .o_done(done), .o_error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    int          at;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] tb_mem [logic [15:0]];
  logic [31:0] ld_words[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          gap_max = 0;
  int          stalls = 0;
  bit          poke = 1'b0;
  wr_t         mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] model_addr(input int k);
    logic [31:0] a;
    a = BASE + 32'(k) * 32'd4;
    return a[15:0];
  endfunction

  // Monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst) begin
      check("we_follows_valid", {31'd0, d_we}, {31'd0, d_valid});
      if (d_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: addr %h data %h, required no write", d_addr, d_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", {16'd0, d_addr}, {16'd0, mon_e.addr});
          check("wr_data", d_data, mon_e.data);
          check("wr_latency_cycle", cyc, mon_e.at);
        end
        tb_mem[d_addr] = d_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    if (gap_max > 0) idle($urandom_range(0, gap_max));
    s_valid = 1'b1;
    s_data  = b;
    while (s_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    if (s_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: actual ready %b required 1", s_ready);
    end else begin
      tick();
    end
    stalls += w;
    s_valid = 1'b0;
  endtask

  task automatic send_len(input logic [31:0] l);
    for (int b = 0; b < 4; b++) send_byte(l[8*b +: 8]);
  endtask

  task automatic send_word(input int k, input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      if (poke && b == 2) start = 1'b1;
      send_byte(w[8*b +: 8]);
      start = 1'b0;
      if (b == 3) exp_q.push_back('{addr: model_addr(k), data: w, at: cyc});
    end
    poke = 1'b0;
  endtask

  task automatic start_pulse();
    s_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("ready_after_start", {31'd0, s_ready}, 32'd1);
    check("done_cleared", {31'd0, done}, 32'd0);
    check("error_cleared", {31'd0, error}, 32'd0);
  endtask

  // One complete load; off is added to the correct checksum trailer.
  task automatic run_load(input logic [31:0] len, input logic [31:0] off);
    logic [31:0] sum;
    logic [31:0] got;
    bit          exp_err;
    int          t;
    sum = 32'd0;
    while (len <= MAXW && ld_words.size() < int'(len)) ld_words.push_back($urandom);
    tb_mem.delete();
    stalls = 0;
    start_pulse();
    send_len(len);
    if (len > MAXW) begin
      check("hdr_err_flag", {31'd0, error}, 32'd1);
      check("hdr_err_ready", {31'd0, s_ready}, 32'd0);
      check("hdr_err_done", {31'd0, done}, 32'd0);
      check("hdr_err_busy", {31'd0, busy}, 32'd0);
      idle(3);
      check("hdr_err_no_write", exp_q.size(), 32'd0);
    end else begin
      for (int k = 0; k < int'(len); k++) begin
        send_word(k, ld_words[k]);
        sum += ld_words[k];
`ifndef MEM_LOADER_CHECKSUM_EN
        if (k == int'(len) - 1) begin
          check("done_with_last_strobe", {30'd0, done, d_valid}, 32'd3);
        end
`endif
      end
`ifdef MEM_LOADER_CHECKSUM_EN
      send_len(sum + off);
      exp_err = (off != 32'd0);
`else
      exp_err = 1'b0;
`endif
      t = 0;
      while (!(done === 1'b1 || error === 1'b1) && t < 20) begin
        tick();
        t++;
      end
      check("end_done", {31'd0, done}, {31'd0, !exp_err});
      check("end_error", {31'd0, error}, {31'd0, exp_err});
      check("end_busy", {31'd0, busy}, 32'd0);
      check("end_ready", {31'd0, s_ready}, 32'd0);
      tick();
      check("queue_drained", exp_q.size(), 32'd0);
      for (int k = 0; k < int'(len); k++) begin
        got = tb_mem.exists(model_addr(k)) ? tb_mem[model_addr(k)] : 32'hxxxx_xxxx;
        check("mem_word", got, ld_words[k]);
      end
    end
    ld_words.delete();
  endtask

  task automatic check_quiet(input string nm);
    check({nm, "_ready"}, {31'd0, s_ready}, 32'd0);
    check({nm, "_valid"}, {31'd0, d_valid}, 32'd0);
    check({nm, "_we"}, {31'd0, d_we}, 32'd0);
    check({nm, "_busy"}, {31'd0, busy}, 32'd0);
    check({nm, "_done"}, {31'd0, done}, 32'd0);
    check({nm, "_error"}, {31'd0, error}, 32'd0);
    check({nm, "_addr"}, {16'd0, d_addr}, 32'd0);
    check({nm, "_data"}, d_data, 32'd0);
  endtask

  initial begin
    logic [31:0] got;
    // Reset values.
    rst = 1'b1;
    tick();
    tick();
    check_quiet("reset");
    rst = 1'b0;

    // Bytes offered while idle must not be consumed.
    s_valid = 1'b1;
    s_data  = 8'hAA;
    repeat (3) begin
      tick();
      check("idle_ready_low", {31'd0, s_ready}, 32'd0);
    end
    s_valid = 1'b0;

    // L=1, word 0x12345678.
    gap_max = 0;
    ld_words.push_back(32'h1234_5678);
    run_load(32'd1, 32'd0);

    // L=3 back-to-back, with a stray i_start mid-data that must be ignored.
    poke = 1'b1;
    run_load(32'd3, 32'd0);
    check("ready_never_low", stalls, 32'd0);

    // Oversize header, then a clean restart.
    run_load(MAXW + 32'd1, 32'd0);
    run_load(32'd2, 32'd0);

    // Reset after two bytes of word 1 in an L=2 load.
    tb_mem.delete();
    start_pulse();
    send_len(32'd2);
    send_word(0, 32'hCAFE_0001);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1;
    tick();
    check_quiet("midrst");
    rst = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h33;
    idle(4);
    check("midrst_queue", exp_q.size(), 32'd0);
    check("midrst_no_word1", {31'd0, tb_mem.exists(model_addr(1)) != 0}, 32'd0);
    got = tb_mem.exists(model_addr(0)) ? tb_mem[model_addr(0)] : 32'hxxxx_xxxx;
    check("midrst_word0", got, 32'hCAFE_0001);
    run_load(32'd2, 32'd0);

    // Boundaries: empty image and exactly MAX_WORDS with random gaps.
    run_load(32'd0, 32'd0);
    gap_max = 2;
    run_load(MAXW, 32'd0);

    // Sum wraps mod 2^32: correct trailer, then an all-zero trailer.
    gap_max = 0;
    ld_words.push_back(32'hFFFF_FFFF);
    ld_words.push_back(32'h0000_0002);
    run_load(32'd2, 32'd0);
    ld_words.push_back(32'hFFFF_FFFF);
    ld_words.push_back(32'h0000_0002);
    run_load(32'd2, 32'hFFFF_FFFF);

    // Randomised loads.
    for (int i = 0; i < 12; i++) begin
      gap_max = $urandom_range(0, 2);
      run_load(32'($urandom_range(0, MAXW + 1)),
               ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 255)) : 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
